// File: rtl/vpu_ctrl_pkg.sv
// rtl/vpu_ctrl_pkg.sv - shared types for the instruction-memory arbiter
package vpu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    LOAD   = 2'd2,
    LOCKED = 2'd3
  } arb_state_t;

  typedef enum logic {
    WIN_FETCH = 1'b0,
    WIN_LOAD  = 1'b1
  } winner_t;

  localparam logic [1:0] OWNER_IDLE   = 2'd0;
  localparam logic [1:0] OWNER_FETCH  = 2'd1;
  localparam logic [1:0] OWNER_LOAD   = 2'd2;
  localparam logic [1:0] OWNER_LOCKED = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter for debug statistics
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/instr_mem_arbiter.sv
// rtl/instr_mem_arbiter.sv - round-robin share of the instruction RAM between
// FSM fetch reads and UART loader writes, with loader lock and debug counters
module instr_mem_arbiter
  import vpu_ctrl_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int INSTR_DEPTH = 256,
  parameter int ADDR_WIDTH  = $clog2(INSTR_DEPTH),
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_req,
  input  logic [ADDR_WIDTH-1:0]  fetch_addr,
  output logic                   fetch_gnt,
  output logic                   fetch_rvalid,
  output logic [INSTR_WIDTH-1:0] fetch_rdata,
  input  logic                   load_lock,
  input  logic                   load_req,
  input  logic [ADDR_WIDTH-1:0]  load_addr,
  input  logic [INSTR_WIDTH-1:0] load_wdata,
  output logic                   load_gnt,
  output logic                   load_err,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [INSTR_WIDTH-1:0] mem_wdata,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic [1:0]             owner,
  output logic [CNT_WIDTH-1:0]   stall_cnt,
  output logic [CNT_WIDTH-1:0]   write_cnt
);

  // One extra bit so a depth equal to 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(INSTR_DEPTH);

  arb_state_t             state;
  winner_t                last_winner;
  logic                   rvalid_q;
  logic [INSTR_WIDTH-1:0] rdata_q;
  logic                   load_oor;

  // Grants are masked while rst_n is low so nothing reaches the RAM in reset.
  always_comb begin
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    load_err  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    load_oor  = ({1'b0, load_addr} >= DEPTH_LIMIT);

    if (rst_n) begin
      if (load_lock) begin
        load_gnt = load_req;
      end else if (fetch_req && load_req) begin
        if (last_winner == WIN_LOAD) fetch_gnt = 1'b1;
        else                         load_gnt  = 1'b1;
      end else begin
        fetch_gnt = fetch_req;
        load_gnt  = load_req;
      end
    end

    if (fetch_gnt) begin
      mem_en   = 1'b1;
      mem_addr = fetch_addr;
    end else if (load_gnt) begin
      if (load_oor) begin
        load_err = 1'b1;
      end else begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = load_addr;
        mem_wdata = load_wdata;
      end
    end
  end

  // Holding last_winner at LOAD during lock hands the first tie after release to fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_winner <= WIN_LOAD;
    end else begin
      if (load_lock)      state <= LOCKED;
      else if (fetch_gnt) state <= FETCH;
      else if (load_gnt)  state <= LOAD;
      else                state <= IDLE;

      if (load_lock)      last_winner <= WIN_LOAD;
      else if (fetch_gnt) last_winner <= WIN_FETCH;
      else if (load_gnt)  last_winner <= WIN_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= fetch_gnt;
      if (rvalid_q) rdata_q <= mem_rdata;
    end
  end

  // Data is forwarded from the RAM in the rvalid cycle and held from the register after.
  assign fetch_rvalid = rvalid_q;
  assign fetch_rdata  = rvalid_q ? mem_rdata : rdata_q;
  assign owner        = state;

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fetch_req && !fetch_gnt),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_write_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (load_gnt && !load_err),
    .count (write_cnt)
  );

endmodule
